// File: rtl/memory_f2_down_3_ctrl_if.sv
// rtl/memory_f2_down_3_ctrl_if.sv - request/response bundle for the f2_down_3 word-time controller
interface memory_f2_down_3_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_long;
  logic [4:0]  req_addr;
  logic [34:0] req_wdata;
  logic        rsp_valid;
  logic [34:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_long, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_long, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/memory_f2_down_3_ctrl.sv
// rtl/memory_f2_down_3_ctrl.sv - word-time controller for delay-line tank f2_down_3
// Optional write read-back check enabled by defining MEM_F2_WRITE_VERIFY_EN.
module memory_f2_down_3_ctrl (
  input  logic                   f2_clk,
  input  logic                   f2_rst,
  memory_f2_down_3_ctrl_if.slave bus,
  output logic                   f2_mib,
  output logic                   f2_down_t3_clr,
  output logic                   f2_down_t3_in,
  output logic                   f2_down_t3_out,
  input  logic                   f2_down_mob_t3,
  output logic [4:0]             digit_pos,
  output logic [4:0]             minor_pos
);
  localparam int DIGITS  = 18;
  localparam int MINORS  = 32;
  localparam int LONG_W  = 35;
  localparam int SHORT_W = DIGITS - 1;

  localparam logic [4:0] LAST_DIGIT = 5'(DIGITS - 1);
  localparam logic [4:0] LAST_MINOR = 5'(MINORS - 1);

`ifdef MEM_F2_WRITE_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CHECK, WAIT, XFER, VERIFY, VREAD, DONE} state_t;

  state_t      state;
  logic        write_q;
  logic        long_q;
  logic [4:0]  addr_q;
  logic [34:0] wdata_q;
  logic [34:0] rbuf;
  logic [5:0]  cnt;
  logic        verr;

  logic        at_head;
  logic [5:0]  last_slot;
  logic [5:0]  data_bits;
  logic [5:0]  nxt;
  logic        nxt_bit;

  // The word reaches the tank head right after slot 17 of the preceding minor cycle.
  assign at_head   = (digit_pos == LAST_DIGIT) && (minor_pos == (addr_q - 5'd1));
  assign last_slot = long_q ? 6'(2 * DIGITS - 1) : 6'(DIGITS - 1);
  assign data_bits = long_q ? 6'(LONG_W) : 6'(SHORT_W);
  assign nxt       = cnt + 6'd1;
  assign nxt_bit   = (nxt < data_bits) ? wdata_q[nxt] : 1'b0;

  always_ff @(posedge f2_clk or posedge f2_rst) begin
    if (f2_rst) begin
      digit_pos <= '0;
      minor_pos <= '0;
    end else if (digit_pos == LAST_DIGIT) begin
      digit_pos <= '0;
      minor_pos <= (minor_pos == LAST_MINOR) ? '0 : minor_pos + 5'd1;
    end else begin
      digit_pos <= digit_pos + 5'd1;
    end
  end

  always_ff @(posedge f2_clk or posedge f2_rst) begin
    if (f2_rst) begin
      state          <= IDLE;
      write_q        <= 1'b0;
      long_q         <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rbuf           <= '0;
      cnt            <= '0;
      verr           <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_err    <= 1'b0;
      f2_mib         <= 1'b0;
      f2_down_t3_clr <= 1'b0;
      f2_down_t3_in  <= 1'b0;
      f2_down_t3_out <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            write_q       <= bus.req_write;
            long_q        <= bus.req_long;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            rbuf          <= '0;
            verr          <= 1'b0;
            bus.req_ready <= 1'b0;
            state         <= CHECK;
          end
        end
        CHECK: begin
          if (long_q && addr_q[0]) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            state         <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (at_head) begin
            cnt            <= '0;
            f2_mib         <= write_q & wdata_q[0];
            f2_down_t3_clr <= write_q;
            f2_down_t3_in  <= write_q;
            f2_down_t3_out <= ~write_q;
            state          <= XFER;
          end
        end
        XFER: begin
          if (!write_q && (cnt < data_bits))
            rbuf[cnt] <= f2_down_mob_t3;
          if (cnt == last_slot) begin
            f2_mib         <= 1'b0;
            f2_down_t3_clr <= 1'b0;
            f2_down_t3_in  <= 1'b0;
            f2_down_t3_out <= 1'b0;
            if (write_q && VERIFY_EN) begin
              state <= VERIFY;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              if (!write_q)
                bus.rsp_rdata <= rbuf;
              state <= DONE;
            end
          end else begin
            cnt    <= nxt;
            f2_mib <= write_q & nxt_bit;
          end
        end
        VERIFY: begin
          // Same head condition as WAIT, one circulation after the write began.
          if (at_head) begin
            cnt            <= '0;
            f2_down_t3_out <= 1'b1;
            state          <= VREAD;
          end
        end
        VREAD: begin
          if ((cnt < data_bits) && (f2_down_mob_t3 != wdata_q[cnt]))
            verr <= 1'b1;
          if (cnt == last_slot) begin
            f2_down_t3_out <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_err    <= verr;
            state          <= DONE;
          end else begin
            cnt <= nxt;
          end
        end
        DONE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_f2_down_3_ctrl.sv
// tb/tb_memory_f2_down_3_ctrl.sv - directed bench for memory_f2_down_3_ctrl with a model tank
module tb_memory_f2_down_3_ctrl;
`ifdef MEM_F2_WRITE_VERIFY_EN
  localparam int VRD = 18;
`else
  localparam int VRD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mib, clr, tin, tout, mob;
  logic [4:0] dpos, mpos;
  memory_f2_down_3_ctrl_if bus();

  memory_f2_down_3_ctrl dut (
    .f2_clk(clk), .f2_rst(rst), .bus(bus), .f2_mib(mib),
    .f2_down_t3_clr(clr), .f2_down_t3_in(tin), .f2_down_t3_out(tout),
    .f2_down_mob_t3(mob), .digit_pos(dpos), .minor_pos(mpos)
  );

  always #5 clk = ~clk;

  // Bench-side position counter and tank model
  logic [4:0] tb_digit, tb_minor;
  logic       pre [576];
  logic       tank [576];
  logic       written [576];
  logic       corrupt = 1'b0;
  int         slot;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_digit <= 5'd0;
      tb_minor <= 5'd0;
    end else if (tb_digit == 5'd17) begin
      tb_digit <= 5'd0;
      tb_minor <= tb_minor + 5'd1;
    end else begin
      tb_digit <= tb_digit + 5'd1;
    end
  end

  assign slot = int'(tb_minor) * 18 + int'(tb_digit);
  assign mob  = tout ? (written[slot] ? tank[slot] : pre[slot]) : 1'b0;

  always @(posedge clk) begin
    if (clr && tin) begin
      tank[slot]    = (corrupt && tb_digit == 5'd4) ? ~mib : mib;
      written[slot] = 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  int n_wr, n_rd, n_any, rsp_c, last_c, pos_bad, stray;
  logic        rsp_err_q, ready_in_rsp, ready_after;
  logic [34:0] rsp_q;
  logic [4:0]  lg_minor [64];
  logic [4:0]  lg_digit [64];
  logic        lg_mib [64];

  task automatic preload(input int base, input logic [34:0] v, input int nbits);
    for (int k = 0; k < nbits; k++) pre[base + k] = v[k];
    pre[base + nbits] = 1'b1;
  endtask

  // Issues one request starting just after a negedge and logs every strobe cycle.
  task automatic do_req(input logic w, input logic l, input logic [4:0] a,
                        input logic [34:0] d, input bit noise);
    n_wr = 0; n_rd = 0; n_any = 0; rsp_c = -1; last_c = -1; pos_bad = 0; stray = 0;
    ready_in_rsp = 1'bx; ready_after = 1'bx; rsp_err_q = 1'bx; rsp_q = 'x;
    bus.req_write = w; bus.req_long = l; bus.req_addr = a; bus.req_wdata = d;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (noise) begin
      bus.req_write = 1'b1; bus.req_long = 1'b0; bus.req_addr = 5'd9; bus.req_wdata = 35'h1FFFF;
    end
    for (int c = 1; c <= 1400 && rsp_c < 0; c++) begin
      @(negedge clk);
      if (noise) bus.req_valid = (c >= 2 && c <= 300 && (c % 5) == 0);
      if (dpos !== tb_digit || mpos !== tb_minor) pos_bad++;
      if (mib && !tin) stray++;
      if (clr || tin || tout) begin
        if (n_any < 64) begin
          lg_minor[n_any] = tb_minor; lg_digit[n_any] = tb_digit; lg_mib[n_any] = mib;
        end
        n_any++;
        last_c = c;
      end
      if (clr && tin) n_wr++;
      if (tout) n_rd++;
      if (bus.rsp_valid === 1'b1) begin
        rsp_c = c; rsp_err_q = bus.rsp_err; rsp_q = bus.rsp_rdata; ready_in_rsp = bus.req_ready;
      end
    end
    bus.req_valid = 1'b0;
    if (rsp_c >= 0) begin
      @(negedge clk);
      ready_after = bus.req_ready;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({clr, tin, tout, mib, bus.rsp_valid, bus.rsp_err} !== 6'b0) begin errors++;
      $display("FAIL reset_outputs got %b want 000000", {clr, tin, tout, mib, bus.rsp_valid, bus.rsp_err}); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.rsp_rdata !== 35'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.rsp_rdata); end
    checks++; if (dpos !== 5'd0 || mpos !== 5'd0) begin errors++; $display("FAIL reset_pos got %0d/%0d want 0/0", mpos, dpos); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dpos !== 5'd1 || mpos !== 5'd0) begin errors++; $display("FAIL pos_step got %0d/%0d want 0/1", mpos, dpos); end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit seen;
    bus.req_write = 1'b1; bus.req_long = 1'b0; bus.req_wdata = 35'h1FFFF;
    bus.req_addr = 5'((int'(tb_minor) + 10) % 32);
    bus.req_valid = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL wait_busy got %b want 0", bus.req_ready); end
    #2 rst = 1'b1; #1;
    checks++; if ({clr, tin, tout, mib, bus.rsp_valid} !== 5'b0 || bus.req_ready !== 1'b1) begin errors++;
      $display("FAIL rst_wait_out got %b ready %b want 00000 ready 1", {clr, tin, tout, mib, bus.rsp_valid}, bus.req_ready); end
    @(negedge clk); rst = 1'b0;
    checks++; if (dpos !== 5'd0 || mpos !== 5'd0) begin errors++; $display("FAIL rst_wait_pos got %0d/%0d want 0/0", mpos, dpos); end
    n = 0;
    repeat (600) begin @(negedge clk); if (clr || tin || tout || bus.rsp_valid) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL rst_wait_stale got %0d want 0", n); end
    // Reset again while a write is in XFER.
    bus.req_addr = 5'((int'(tb_minor) + 2) % 32);
    bus.req_valid = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin @(negedge clk); if (clr) seen = 1; end
    repeat (3) @(negedge clk);
    checks++; if (!seen || mib !== 1'b1) begin errors++; $display("FAIL xfer_reach got seen=%0d mib=%b want 1/1", seen, mib); end
    #2 rst = 1'b1; #1;
    checks++; if ({clr, tin, tout, mib} !== 4'b0) begin errors++; $display("FAIL rst_xfer_out got %b want 0000", {clr, tin, tout, mib}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_short_write();
    logic [34:0] d;
    int bad;
    d = 35'h1_5A5A;
    do_req(1'b1, 1'b0, 5'd5, d, 1'b0);
    checks++; if (n_wr != 18 || n_rd != VRD) begin errors++; $display("FAIL sw_count got wr %0d rd %0d want 18 %0d", n_wr, n_rd, VRD); end
    bad = 0;
    for (int k = 0; k < 18; k++) if (lg_minor[k] !== 5'd5 || lg_digit[k] !== 5'(k)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL sw_slots got %0d bad want 0", bad); end
    bad = 0;
    for (int k = 0; k < 18; k++) if (lg_mib[k] !== ((k < 17) ? d[k] : 1'b0)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL sw_mib got %0d bad bits want 0", bad); end
    checks++; if (rsp_c != last_c + 1 || rsp_err_q !== 1'b0) begin errors++;
      $display("FAIL sw_rsp got c=%0d err=%b want c=%0d err=0", rsp_c, rsp_err_q, last_c + 1); end
    checks++; if (ready_in_rsp !== 1'b0 || ready_after !== 1'b1) begin errors++;
      $display("FAIL sw_ready got %b%b want 01", ready_in_rsp, ready_after); end
    checks++; if (pos_bad != 0 || stray != 0) begin errors++; $display("FAIL sw_pos_stray got %0d/%0d want 0/0", pos_bad, stray); end
  endtask

  task automatic test_long_read();
    logic [34:0] v;
    int bad;
    v = 35'h5_0F0F_0F0F;
    preload(30 * 18, v, 35);
    do_req(1'b0, 1'b1, 5'd30, 35'd0, 1'b0);
    checks++; if (n_rd != 36 || n_wr != 0) begin errors++; $display("FAIL lr_count got rd %0d wr %0d want 36 0", n_rd, n_wr); end
    bad = 0;
    for (int k = 0; k < 36; k++) if (lg_minor[k] !== 5'(30 + k / 18) || lg_digit[k] !== 5'(k % 18)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL lr_slots got %0d bad want 0", bad); end
    checks++; if (rsp_q !== v || rsp_err_q !== 1'b0) begin errors++;
      $display("FAIL lr_data got %h err %b want %h err 0", rsp_q, rsp_err_q, v); end
  endtask

  task automatic test_odd_long();
    do_req(1'b1, 1'b1, 5'd7, 35'h7_FFFF_FFFF, 1'b0);
    checks++; if (rsp_c != 2 || rsp_err_q !== 1'b1) begin errors++;
      $display("FAIL odd_rsp got c=%0d err=%b want c=2 err=1", rsp_c, rsp_err_q); end
    checks++; if (n_any != 0) begin errors++; $display("FAIL odd_strobes got %0d want 0", n_any); end
  endtask

  task automatic test_short_read_wrap();
    logic [34:0] v;
    bit found;
    v = 35'h0_1234;
    preload(0, v, 17);
    found = 0;
    for (int c = 0; c < 700 && !found; c++) begin
      @(negedge clk);
      if (tb_minor == 5'd0 && tb_digit == 5'd3) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL sr_align got 0 want 1"); end
    do_req(1'b0, 1'b0, 5'd0, 35'd0, 1'b1);
    checks++; if (n_rd != 18 || n_wr != 0 || lg_minor[0] !== 5'd0 || lg_digit[0] !== 5'd0) begin errors++;
      $display("FAIL sr_strobes got rd %0d wr %0d first %0d/%0d want 18 0 0/0", n_rd, n_wr, lg_minor[0], lg_digit[0]); end
    checks++; if (rsp_c != 591) begin errors++; $display("FAIL sr_latency got %0d want 591", rsp_c); end
    checks++; if (rsp_q !== v || rsp_err_q !== 1'b0) begin errors++;
      $display("FAIL sr_data got %h err %b want %h err 0", rsp_q, rsp_err_q, v); end
  endtask

  task automatic test_back_to_back();
    logic [34:0] d;
    d = 35'h2_ABCD_1234;
    do_req(1'b1, 1'b1, 5'd12, d, 1'b0);
    checks++; if (n_wr != 36 || lg_minor[0] !== 5'd12 || lg_minor[35] !== 5'd13 || lg_mib[35] !== 1'b0 || rsp_err_q !== 1'b0) begin
      errors++; $display("FAIL lw_xfer got wr %0d minors %0d..%0d guard %b err %b want 36 12..13 0 0",
                         n_wr, lg_minor[0], lg_minor[35], lg_mib[35], rsp_err_q); end
    do_req(1'b0, 1'b1, 5'd12, 35'd0, 1'b0);
    checks++; if (rsp_q !== d) begin errors++; $display("FAIL b2b_long got %h want %h", rsp_q, d); end
    do_req(1'b0, 1'b0, 5'd5, 35'd0, 1'b0);
    checks++; if (rsp_q !== 35'h1_5A5A) begin errors++; $display("FAIL b2b_short got %h want 15a5a", rsp_q); end
  endtask

`ifdef MEM_F2_WRITE_VERIFY_EN
  task automatic test_write_verify();
    corrupt = 1'b1;
    do_req(1'b1, 1'b0, 5'd8, 35'h0_00FF, 1'b0);
    corrupt = 1'b0;
    checks++; if (rsp_err_q !== 1'b1 || n_rd != 18 || rsp_c < 576) begin errors++;
      $display("FAIL verify_err got err %b rd %0d c %0d want 1 18 >=576", rsp_err_q, n_rd, rsp_c); end
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_long = 1'b0;
    bus.req_addr = 5'd0; bus.req_wdata = 35'd0;
    for (int i = 0; i < 576; i++) begin pre[i] = 1'b0; tank[i] = 1'b0; written[i] = 1'b0; end
    test_reset();
    test_reset_mid_wait();
    test_short_write();
    test_long_read();
    test_odd_long();
    test_short_read_wrap();
    test_back_to_back();
`ifdef MEM_F2_WRITE_VERIFY_EN
    test_write_verify();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
